rng_share_arbiter: RTL and testbench

//  Shares one 32-bit xorshift PRNG (shifts 13/17/5) among NUM_REQ game-logic requesters.

---
 rtl/rng_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rng_share_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_share_arbiter.sv
// rng_share_arbiter: round-robin access to one shared xorshift32 PRNG.
// Each grant steps the PRNG once and scales the new word into [0, bound).
module rng_share_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter int          BOUND_W = 16,
    parameter logic [31:0] SEED    = 32'hACE1BEEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BOUND_W-1:0] req_bound,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [BOUND_W-1:0]         rsp_value,
    output logic [31:0]                rsp_raw,
    input  logic                       seed_load,
    input  logic [31:0]                seed_value,
    output logic                       busy
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int PROD_W = 32 + BOUND_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        SCALE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         prng_q, prng_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BOUND_W-1:0]  bound_q, bound_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [BOUND_W-1:0]  rsp_value_q, rsp_value_d;
    logic [31:0]         rsp_raw_q, rsp_raw_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  grant_s;
    logic                found_s;
    logic [ID_W-1:0]     winner_s;
    logic [ID_W-1:0]     idx_s;
    logic [PROD_W-1:0]   prod_s;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Round-robin search starting just after the last winner.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        idx_s    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found_s && req_valid[idx_s]) begin
                found_s  = 1'b1;
                winner_s = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state, PRNG and response datapath.
    always_comb begin
        state_d     = state_q;
        prng_d      = prng_q;
        rr_ptr_d    = rr_ptr_q;
        bound_d     = bound_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        rsp_value_d = rsp_value_q;
        rsp_raw_d   = rsp_raw_q;
        grant_s     = '0;
        prod_s      = PROD_W'(prng_q) * PROD_W'(bound_q);
        case (state_q)
            IDLE: begin
                // A seed load owns the cycle; no grant alongside it.
                if (seed_load) begin
                    prng_d = (seed_value == 32'd0) ? SEED : seed_value;
                end else if (found_s) begin
                    grant_s[winner_s] = 1'b1;
                    bound_d  = req_bound[winner_s*BOUND_W +: BOUND_W];
                    id_d     = winner_s;
                    rr_ptr_d = winner_s;
                    state_d  = STEP;
                end else begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                prng_d  = xs32(prng_q);
                state_d = SCALE;
            end
            SCALE: begin
                if (bound_q == '0) begin
                    rsp_value_d = prng_q[BOUND_W-1:0];
                end else begin
                    rsp_value_d = BOUND_W'(prod_s >> 32'd32);
                end
                rsp_raw_d = prng_q;
                rsp_id_d  = id_q;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // FSM, PRNG state and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prng_q      <= SEED;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            bound_q     <= '0;
            id_q        <= '0;
            rsp_id_q    <= '0;
            rsp_value_q <= '0;
            rsp_raw_q   <= 32'd0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prng_q      <= prng_d;
            rr_ptr_q    <= rr_ptr_d;
            bound_q     <= bound_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            rsp_value_q <= rsp_value_d;
            rsp_raw_q   <= rsp_raw_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_value = rsp_value_q;
    assign rsp_raw   = rsp_raw_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Bench for rng_share_arbiter: directed vectors plus randomized traffic,
// checked against a transaction-level model of the arbiter and the PRNG.
module tb_rng_share_arbiter;

    localparam logic [31:0] TB_SEED = 32'h00000001;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_bound;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_value;
    logic [31:0] rsp_raw;
    logic        seed_load;
    logic [31:0] seed_value;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_state;
    int          m_last;

    int          w, gcount, last_t, due, e_id;
    logic [3:0]  oh;
    logic [15:0] bw, e_val;
    logic [31:0] e_raw;

    rng_share_arbiter #(
        .NUM_REQ(4),
        .BOUND_W(16),
        .SEED   (TB_SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_bound (req_bound),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_value (rsp_value),
        .rsp_raw   (rsp_raw),
        .seed_load (seed_load),
        .seed_value(seed_value),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: xorshift32 written as multiply/divide by powers of two.
    function automatic logic [31:0] m_xs(input logic [31:0] x);
        logic [31:0] a;
        a = x ^ (x * 32'd8192);
        a = a ^ (a / 32'd131072);
        a = a ^ (a * 32'd32);
        return a;
    endfunction

    function automatic logic [15:0] m_scale(input logic [31:0] r, input logic [15:0] b);
        logic [63:0] p;
        if (b == 16'd0) return r[15:0];
        p = {32'd0, r} * {48'd0, b};
        return p[47:32];
    endfunction

    function automatic int m_pick(input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] rb();
        case ($urandom_range(0, 3))
            0:       return 16'd0;
            1:       return 16'd1;
            2:       return 16'($urandom_range(2, 100));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic zero_chk(input string p);
        chk({p, "_req_ready"}, req_ready, 0);
        chk({p, "_rsp_valid"}, rsp_valid, 0);
        chk({p, "_rsp_id"}, rsp_id, 0);
        chk({p, "_rsp_value"}, rsp_value, 0);
        chk({p, "_rsp_raw"}, rsp_raw, 0);
        chk({p, "_busy"}, busy, 0);
    endtask

    // One full transaction from an IDLE cycle; hold = cycles rsp_ready stays low in RESP.
    task automatic do_request(input logic [3:0] v, input logic [63:0] b, input int hold);
        int          wi;
        logic [3:0]  one_hot;
        logic [15:0] bnd, val;
        logic [31:0] raw;
        req_valid = v;
        req_bound = b;
        rsp_ready = 1'b0;
        #1;
        wi = m_pick(v);
        if (wi < 0) begin
            chk("idle_no_grant", req_ready, 0);
            chk("idle_busy", busy, 0);
            req_valid = 4'b0000;
            cyc();
            return;
        end
        one_hot = 4'b0001 << wi;
        chk("grant", req_ready, one_hot);
        chk("grant_busy", busy, 0);
        bnd     = b[wi*16 +: 16];
        m_last  = wi;
        m_state = m_xs(m_state);
        raw     = m_state;
        val     = m_scale(raw, bnd);
        cyc();
        req_valid  = 4'b0000;
        req_bound  = {rb(), rb(), rb(), rb()};
        seed_load  = 1'($urandom_range(0, 1));
        seed_value = $urandom;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lat_valid", rsp_valid, 0);
            chk("lat_busy", busy, 1);
            chk("lat_ready", req_ready, 0);
            cyc();
        end
        req_valid = 4'b1111;
        for (int h = 0; h < hold; h++) begin
            #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_id", rsp_id, wi);
            chk("hold_raw", rsp_raw, raw);
            chk("hold_value", rsp_value, val);
            chk("hold_ready", req_ready, 0);
            chk("hold_busy", busy, 1);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, wi);
        chk("rsp_raw", rsp_raw, raw);
        chk("rsp_value", rsp_value, val);
        if (bnd != 16'd0) chk("in_range", rsp_value < bnd, 1);
        cyc();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        seed_load = 1'b0;
        #1;
        chk("back_idle", busy, 0);
        chk("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 4'b0000;
        req_bound  = 64'd0;
        rsp_ready  = 1'b0;
        seed_load  = 1'b0;
        seed_value = 32'd0;
        m_state    = TB_SEED;
        m_last     = 3;
        repeat (2) @(posedge clk);
        #1;
        zero_chk("rst");
        reset = 1'b0;
        cyc();

        // Known first words from seed 1.
        do_request(4'b0001, 64'd0, 0);
        chk("v1_raw", rsp_raw, 32'h00042021);
        chk("v1_value", rsp_value, 16'h2021);
        chk("v1_id", rsp_id, 0);
        do_request(4'b0001, {48'd0, 16'd100}, 0);
        chk("v2_value", rsp_value, 16'd1);

        // Back-pressure in RESP.
        do_request(4'b0010, {rb(), rb(), rb(), rb()}, 5);

        // Zero seed falls back to SEED; no grant in the load cycle.
        req_valid  = 4'b0001;
        seed_load  = 1'b1;
        seed_value = 32'd0;
        #1;
        chk("seed_no_grant", req_ready, 0);
        cyc();
        seed_load = 1'b0;
        m_state   = TB_SEED;
        do_request(4'b0001, {rb(), rb(), rb(), rb()}, 0);
        chk("seed_raw", rsp_raw, 32'h00042021);

        // Reset in SCALE aborts the response.
        req_valid = 4'b0001;
        req_bound = {rb(), rb(), rb(), rb()};
        #1;
        chk("rs_grant", req_ready, 4'b0001);
        cyc();
        req_valid = 4'b0000;
        cyc();
        chk("rs_busy", busy, 1);
        reset = 1'b1;
        #1;
        zero_chk("rs");
        cyc();
        reset   = 1'b0;
        m_state = TB_SEED;
        m_last  = 3;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rs_no_rsp", rsp_valid, 0);
            chk("rs_idle", busy, 0);
        end

        // All requesters held: rotation 0,1,2,3,0,1 every 4 cycles.
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_bound = {rb(), rb(), rb(), rb()};
        gcount = 0;
        last_t = -1;
        due    = -1;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (c == 0) chk("rr_first", req_ready, 4'b0001);
            if (c == due) begin
                chk("rr_rsp_valid", rsp_valid, 1);
                chk("rr_raw", rsp_raw, e_raw);
                chk("rr_value", rsp_value, e_val);
                chk("rr_id", rsp_id, e_id);
            end
            if (req_ready != 4'b0000) begin
                w  = m_pick(4'b1111);
                oh = 4'b0001 << w;
                chk("rr_grant", req_ready, oh);
                if (last_t >= 0) chk("rr_gap", c - last_t, 4);
                bw      = req_bound[w*16 +: 16];
                m_last  = w;
                m_state = m_xs(m_state);
                e_raw   = m_state;
                e_val   = m_scale(e_raw, bw);
                e_id    = w;
                due     = c + 3;
                last_t  = c;
                gcount++;
            end
            cyc();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        chk("rr_count", gcount, 6);
        cyc();

        // Randomized traffic with occasional reseeding.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                seed_load  = 1'b1;
                seed_value = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                req_valid  = 4'($urandom_range(0, 15));
                #1;
                chk("rnd_seed_no_grant", req_ready, 0);
                m_state = (seed_value == 32'd0) ? TB_SEED : seed_value;
                cyc();
                seed_load = 1'b0;
            end
            do_request(4'($urandom_range(0, 15)), {rb(), rb(), rb(), rb()}, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
